// File: rtl/rtc3w_burst_master.sv
// 3-wire RTC serial master: command byte followed by a write or read data burst, LSB first.
// Define RTC3W_BURST_EN for multi-byte bursts (len-driven); otherwise every transfer moves one data byte.
module rtc3w_burst_master #(
    parameter int CLK_DIV   = 25,
    parameter int CE_SETUP  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [4:0] len,
    input  logic [7:0] wr_data,
    output logic       wr_req,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       ce,
    output logic       dio_out,
    output logic       dio_oe,
    input  logic       dio_in
);

    localparam int BW = $clog2(8 * (MAX_BURST + 1));
    localparam int PW = $clog2(2 * CLK_DIV);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_RECOV = 3'd5;

    logic [2:0]    state;
    logic [7:0]    cnt;
    logic [PW-1:0] ph;
    logic [BW-1:0] bitcnt, lastbit;
    logic          rd;
    logic [7:0]    sh, buf0, rsh;
    logic [4:0]    nsel;
    logic          active, per_end, sample, byte_first, cnt_end;

`ifdef RTC3W_BURST_EN
    always_comb begin
        nsel = len;
        if (len == 5'd0)
            nsel = 5'd1;
        else if (len > 5'(MAX_BURST))
            nsel = 5'(MAX_BURST);
    end
`else
    logic unused_len;
    assign unused_len = ^len;
    assign nsel       = 5'd1;
`endif

    assign active     = (state == S_CMD) || (state == S_DATA);
    assign per_end    = active && (ph == PW'(2 * CLK_DIV - 1));
    assign sample     = active && (ph == PW'(CLK_DIV - 1));
    assign cnt_end    = (cnt == 8'(CE_SETUP - 1));
    // Bytes after the first are fetched on their own first low-half cycle;
    // byte 0 was already captured when the start was accepted.
    assign byte_first = (state == S_DATA) && (ph == '0) && (bitcnt[2:0] == 3'd0)
                        && (bitcnt[BW-1:3] != (BW-3)'(1));

    assign sclk    = active && (ph >= PW'(CLK_DIV));
    assign ce      = (state != S_IDLE) && (state != S_RECOV);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_RECOV) && cnt_end;
    assign dio_oe  = (state == S_CMD) || ((state == S_DATA) && !rd);
    assign dio_out = dio_oe && (byte_first ? wr_data[0] : sh[0]);
    assign wr_req  = ((state == S_IDLE) && start && !cmd[0]) || (byte_first && !rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ph       <= '0;
            bitcnt   <= '0;
            lastbit  <= '0;
            rd       <= 1'b0;
            sh       <= '0;
            buf0     <= '0;
            rsh      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_SETUP;
                    cnt     <= '0;
                    rd      <= cmd[0];
                    sh      <= cmd;
                    buf0    <= wr_data;
                    lastbit <= BW'(8 * (int'(nsel) + 1) - 1);
                end
                S_SETUP: if (cnt_end) begin
                    state  <= S_CMD;
                    ph     <= '0;
                    bitcnt <= '0;
                end else cnt <= cnt + 8'd1;
                S_CMD, S_DATA: begin
                    ph <= per_end ? '0 : ph + 1'b1;
                    if (byte_first && !rd)
                        sh <= wr_data;
                    if (sample && rd && (state == S_DATA)) begin
                        rsh <= {dio_in, rsh[7:1]};
                        if (bitcnt[2:0] == 3'd7) begin
                            rd_data  <= {dio_in, rsh[7:1]};
                            rd_valid <= 1'b1;
                        end
                    end
                    if (per_end) begin
                        if (bitcnt == lastbit) begin
                            state <= S_HOLD;
                            cnt   <= '0;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            if (bitcnt == BW'(7)) begin
                                state <= S_DATA;
                                sh    <= buf0;
                            end else sh <= sh >> 1;
                        end
                    end
                end
                S_HOLD: if (cnt_end) begin
                    state <= S_RECOV;
                    cnt   <= '0;
                end else cnt <= cnt + 8'd1;
                S_RECOV: if (cnt_end) state <= S_IDLE;
                         else cnt <= cnt + 8'd1;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc3w_burst_master.sv
// Directed bench for rtc3w_burst_master: bus capture at sclk rises, upstream byte feeder and a read slave.
module tb_rtc3w_burst_master;

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, dio_in = 1'b0;
    logic [7:0] cmd = 8'h00, wr_data = 8'h00;
    logic [4:0] len = 5'd0;
    logic       wr_req, rd_valid, busy, done, sclk, ce, dio_out, dio_oe;
    logic [7:0] rd_data;

    rtc3w_burst_master #(.CLK_DIV(2), .CE_SETUP(4), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .len(len), .wr_data(wr_data),
        .wr_req(wr_req), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .sclk(sclk), .ce(ce), .dio_out(dio_out), .dio_oe(dio_oe), .dio_in(dio_in)
    );

    always #5 clk = ~clk;

    int npass = 0, ntot = 0, nfail = 0;
    int rises, wrcnt, rvcnt, donecnt, cecnt, oebad, widx;
    bit pend, psclk, to;
    logic       cap [0:79];
    logic [7:0] wdat [0:15];
    logic [7:0] sbyte, last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int expn(input int l);
`ifdef RTC3W_BURST_EN
        if (l == 0) return 1;
        if (l > 8) return 8;
        return l;
`else
        return 1;
`endif
    endfunction

    function automatic logic [7:0] getbyte(input int k);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = cap[8*k+i];
        return b;
    endfunction

    task automatic clr();
        rises = 0; wrcnt = 0; rvcnt = 0; donecnt = 0; cecnt = 0; oebad = 0;
        widx = 0; pend = 0; psclk = 0;
        for (int i = 0; i < 80; i++) cap[i] = 1'bx;
    endtask

    // One clock of observation; called just after a falling edge, returns at the next one.
    task automatic tick(input bit rdx);
        #1;
        if (wr_req) begin wrcnt++; pend = 1; end
        if (ce) cecnt++;
        if (rd_valid) begin rvcnt++; last_rd = rd_data; end
        if (done) donecnt++;
        if (sclk && !psclk) begin
            if (rises < 80) cap[rises] = dio_out;
            if (rdx && rises >= 8 && dio_oe) oebad++;
            rises++;
        end
        psclk = sclk;
        @(negedge clk);
        if (pend) begin widx++; wr_data = wdat[widx]; pend = 0; end
        if (rdx && rises >= 8) dio_in = sbyte[(rises-8)%8];
    endtask

    task automatic xfer(input logic [7:0] c, input logic [4:0] l, input bit rdx, input int poke);
        bit poked = 0;
        clr();
        to = 1;
        wr_data = wdat[0];
        @(negedge clk);
        cmd = c; len = l; start = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick(rdx);
            start = 1'b0;
            if (poke > 0 && rises == poke && !poked) begin
                start = 1'b1; cmd = 8'h81; poked = 1;
            end
            if (donecnt > 0) begin to = 0; break; end
        end
        start = 1'b0;
        chk("xfer_timeout", 32'(to), 32'd0);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_ce",      32'(ce),      32'd0);
        chk("rst_sclk",    32'(sclk),    32'd0);
        chk("rst_oe",      32'(dio_oe),  32'd0);
        chk("rst_dout",    32'(dio_out), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_rdv",     32'(rd_valid),32'd0);
        chk("rst_rddata",  32'(rd_data), 32'd0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single write: 0x80 then 0x59 on the wire
        wdat[0] = 8'h59; wdat[1] = 8'hEE;
        xfer(8'h80, 5'd1, 1'b0, 0);
        chk("w1_rises", 32'(rises), 32'd16);
        chk("w1_bits",  32'({getbyte(1), getbyte(0)}), 32'h5980);
        chk("w1_wrreq", 32'(wrcnt), 32'd1);
        chk("w1_done",  32'(donecnt), 32'd1);
        chk("w1_ce",    32'(cecnt), 32'd72);
        chk("w1_busy",  32'(busy), 32'd0);

        // Single read: slave returns 0x23
        sbyte = 8'h23;
        xfer(8'h81, 5'd1, 1'b1, 0);
        chk("r1_rises", 32'(rises), 32'd16);
        chk("r1_cmd",   32'(getbyte(0)), 32'h81);
        chk("r1_oe",    32'(oebad), 32'd0);
        chk("r1_rdv",   32'(rvcnt), 32'd1);
        chk("r1_byte",  32'(last_rd), 32'h23);
        chk("r1_rddat", 32'(rd_data), 32'h23);
        chk("r1_wrreq", 32'(wrcnt), 32'd0);
        chk("r1_done",  32'(donecnt), 32'd1);

        // Burst write len=8, bytes 0..7
        for (int i = 0; i < 16; i++) wdat[i] = 8'(i);
        xfer(8'hBE, 5'd8, 1'b0, 0);
        n = expn(8);
        chk("b8_rises", 32'(rises), 32'(8*(n+1)));
        chk("b8_wrreq", 32'(wrcnt), 32'(n));
        chk("b8_cmd",   32'(getbyte(0)), 32'hBE);
        for (int k = 0; k < n; k++) chk($sformatf("b8_byte%0d", k), 32'(getbyte(k+1)), 32'(k));

        // len above MAX_BURST clamps
        for (int i = 0; i < 16; i++) wdat[i] = 8'(8'h10 + i);
        xfer(8'hBE, 5'd12, 1'b0, 0);
        n = expn(12);
        chk("b12_rises", 32'(rises), 32'(8*(n+1)));
        chk("b12_wrreq", 32'(wrcnt), 32'(n));
        chk("b12_last",  32'(getbyte(n)), 32'(8'h10 + n - 1));

        // Reset during the 3rd data bit of a read
        clr();
        sbyte = 8'h23;
        @(negedge clk); cmd = 8'h81; len = 5'd1; start = 1'b1;
        to = 1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick(1'b1);
            start = 1'b0;
            if (rises >= 10 && sclk === 1'b0) begin to = 0; break; end
        end
        chk("ra_reach", 32'(to), 32'd0);
        chk("ra_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("ra_ce",     32'(ce), 32'd0);
        chk("ra_sclk",   32'(sclk), 32'd0);
        chk("ra_oe",     32'(dio_oe), 32'd0);
        chk("ra_busy",   32'(busy), 32'd0);
        chk("ra_rddata", 32'(rd_data), 32'd0);
        donecnt = 0;
        repeat (3) tick(1'b0);
        rst = 1'b1;
        repeat (4) tick(1'b0);
        chk("ra_nodone", 32'(donecnt), 32'd0);
        chk("ra_idle",   32'(busy), 32'd0);
        xfer(8'h81, 5'd1, 1'b1, 0);
        chk("ra2_rdv",  32'(rvcnt), 32'd1);
        chk("ra2_byte", 32'(last_rd), 32'h23);
        chk("ra2_done", 32'(donecnt), 32'd1);

        // Start pulse during CMD is ignored
        wdat[0] = 8'hA5; wdat[1] = 8'h3C; wdat[2] = 8'h96; wdat[3] = 8'h0F; wdat[4] = 8'hF0;
        xfer(8'h42, 5'd5, 1'b0, 3);
        n = expn(5);
        chk("p_rises", 32'(rises), 32'(8*(n+1)));
        chk("p_wrreq", 32'(wrcnt), 32'(n));
        chk("p_cmd",   32'(getbyte(0)), 32'h42);
        chk("p_b0",    32'(getbyte(1)), 32'hA5);
        chk("p_blast", 32'(getbyte(n)), 32'(wdat[n-1]));
        repeat (6) @(negedge clk);
        chk("p_idle",  32'(busy), 32'd0);

        // len=0 moves one byte
        wdat[0] = 8'hC3;
        xfer(8'h80, 5'd0, 1'b0, 0);
        chk("z_rises", 32'(rises), 32'd16);
        chk("z_byte",  32'(getbyte(1)), 32'hC3);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/rtc3w_burst_master.md
RTC3W_BURST_MASTER -- requirements
Module: rtc3w_burst_master

Interface
REQ-001 Parameter CLK_DIV, default 25: clk cycles per SCLK half-period; legal 2..255.
REQ-002 Parameter CE_SETUP, default 4: clk cycles of CE setup, hold and recovery; legal 1..255.
REQ-003 Parameter MAX_BURST, default 8: maximum data bytes per transfer; legal 1..31.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request; accepted only in IDLE.
REQ-007 cmd  in  8  command byte; bit0=1 read, bit0=0 write.
REQ-008 len  in  5  data byte count.
REQ-009 wr_data  in  8  write byte currently offered by upstream.
REQ-010 wr_req  out  1  one-cycle pulse: wr_data loaded into shifter; upstream presents next byte.
REQ-011 rd_data  out  8  last received byte, held until next.
REQ-012 rd_valid  out  1  one-cycle pulse per received byte.
REQ-013 busy  out  1  high from accepted start until done.
REQ-014 done  out  1  one-cycle pulse at transfer end.
REQ-015 sclk, ce  out  1 each  serial clock and chip enable.
REQ-016 dio_out, dio_oe  out  1 each  serial data drive value and enable; tristate resolved at top level.
REQ-017 dio_in  in  1  serial data from bus.

Function
REQ-018 States: IDLE -> SETUP -> CMD -> DATA -> HOLD -> RECOV -> IDLE.
REQ-019 IDLE: ce=0, sclk=0, dio_oe=0, busy=0; start latches cmd, len, direction; busy=1 next cycle.
REQ-020 SETUP: ce=1, sclk=0 for CE_SETUP cycles.
REQ-021 Bit period = CLK_DIV cycles sclk low, then CLK_DIV cycles sclk high; bits LSB first.
REQ-022 Driven bits change on first cycle of low half; dio_in sampled on last cycle of low half.
REQ-023 CMD: 8 bit periods, dio_oe=1, shifts cmd.
REQ-024 DATA write: 8*N bit periods, dio_oe=1; each byte loaded from wr_data at its first low-half cycle, wr_req pulses that cycle (byte 0 at start acceptance); N wr_req pulses total.
REQ-025 DATA read: dio_oe=0 from first low half after CMD; 8*N bits sampled; rd_data updated, rd_valid pulsed the cycle after each 8th sample.
REQ-026 HOLD: sclk=0, ce=1 for CE_SETUP cycles; RECOV: ce=0 for CE_SETUP cycles; done pulses on the RECOV->IDLE cycle.
REQ-027 start while busy=1 is ignored; no effect on the running transfer.
REQ-028 Counters sized for 8*(MAX_BURST+1) bits; no wrap within a transfer.

Reset
REQ-029 rst=0 forces IDLE immediately: ce=0, sclk=0, dio_oe=0, dio_out=0, busy=0, done=0, wr_req=0, rd_valid=0, rd_data=0x00, independent of clk.
REQ-030 Reset mid-transfer aborts without done; first start after release runs a full transfer from SETUP.

Configuration
REQ-031 Macro RTC3W_BURST_EN defined: N=len; len=0 -> N=1; len>MAX_BURST -> N=MAX_BURST.
REQ-032 RTC3W_BURST_EN undefined: len ignored, N=1 always; MAX_BURST unused.

Verification (CLK_DIV=2, CE_SETUP=4, MAX_BURST=8, burst enabled unless noted)
REQ-033 Write cmd=0x80, len=1, wr_data=0x59 -> dio_out bits 0,0,0,0,0,0,0,1,1,0,0,1,1,0,1,0 at 16 sclk rises; 1 wr_req; done once; ce high 4+64+4 cycles.
REQ-034 Read cmd=0x81, len=1, slave model returns 0x23 -> dio_oe=0 after 8th rise; rd_data=0x23, rd_valid once; done.
REQ-035 Burst write cmd=0xBE, len=8, bytes 0x00..0x07 -> 72 sclk rises, 8 wr_req, bus bytes match order; len=12 -> exactly 8 bytes.
REQ-036 rst=0 during 3rd data bit of read -> ce, sclk, dio_oe low same cycle, no done; next start completes normally.
REQ-037 start pulse during CMD -> ignored, transfer count unchanged; macro undefined with len=5 -> 16 sclk rises, 1 wr_req.
